player1_ctl: RTL and testbench

//   Motion and animation controller for player 1. Converts level-sensitive move/jump requests

---
 rtl/player1_ctl_if.sv | 22 ++
 rtl/player1_ctl.sv | 147 ++++++++++++++
 tb/tb_player1_ctl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/player1_ctl_if.sv
// Player 1 control bus: keyboard-side move/jump levels in, sprite offsets out.
// frame_tick qualifies the request levels (sampled only while it is high); the offsets and
// airborne are registered and settle one clk after each tick, with no backpressure.
interface player1_ctl_if;
  logic        frame_tick;
  logic        move_left;
  logic        move_right;
  logic        jump;
  logic [11:0] xpos_player1;
  logic [11:0] ypos_player1;
  logic        airborne;

  modport master (
    output frame_tick, move_left, move_right, jump,
    input  xpos_player1, ypos_player1, airborne
  );

  modport slave (
    input  frame_tick, move_left, move_right, jump,
    output xpos_player1, ypos_player1, airborne
  );
endinterface

// File: rtl/player1_ctl.sv
// Player 1 motion/animation controller: per-frame walk with wall clamps, walk-cycle
// animation FSM and a fixed-arc jump with gravity, all advanced on frame_tick.
package state_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RIGHT1 = 3'd1,
    RIGHT2 = 3'd2,
    LEFT1  = 3'd3,
    LEFT2  = 3'd4
  } State;
endpackage

module player1_ctl #(
  parameter int X_START     = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 760,
  parameter int STEP        = 2,
  parameter int ANIM_FRAMES = 8,
  parameter int Y_GROUND    = 100,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int V_MAX       = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  player1_ctl_if.slave    bus,
  output state_pkg::State state
);
  import state_pkg::*;

  typedef enum logic [1:0] {DIR_NONE, DIR_RIGHT, DIR_LEFT} dir_t;

  localparam logic [7:0]         ANIM_LAST  = 8'(ANIM_FRAMES - 1);
  localparam logic signed [13:0] Y_GROUND_S = 14'(Y_GROUND);
  localparam logic signed [8:0]  V_MAX_S    = 9'(V_MAX);

  State              state_q, state_n;
  logic [11:0]       xpos_q, xpos_n;
  logic [11:0]       ypos_q, ypos_n;
  logic              airborne_q, airborne_n;
  logic signed [7:0] vel_q, vel_n;
  logic [7:0]        anim_cnt_q, anim_cnt_n;
  logic              jump_prev_q, jump_prev_n;

  dir_t               dir;
  logic [12:0]        x_wide, x_right;
  logic signed [13:0] y_sum;
  logic signed [8:0]  v_inc;
  logic               launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xpos_q      <= 12'(X_START);
      ypos_q      <= 12'(Y_GROUND);
      airborne_q  <= 1'b0;
      vel_q       <= 8'sd0;
      anim_cnt_q  <= 8'd0;
      jump_prev_q <= 1'b0;
    end else if (bus.frame_tick) begin
      state_q     <= state_n;
      xpos_q      <= xpos_n;
      ypos_q      <= ypos_n;
      airborne_q  <= airborne_n;
      vel_q       <= vel_n;
      anim_cnt_q  <= anim_cnt_n;
      jump_prev_q <= jump_prev_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    xpos_n      = xpos_q;
    ypos_n      = ypos_q;
    airborne_n  = airborne_q;
    vel_n       = vel_q;
    anim_cnt_n  = anim_cnt_q;
    jump_prev_n = bus.jump;

    if (bus.move_right && !bus.move_left)      dir = DIR_RIGHT;
    else if (bus.move_left && !bus.move_right) dir = DIR_LEFT;
    else                                       dir = DIR_NONE;

    // 13-bit working width so the left clamp never sees a wrapped value
    x_wide  = {1'b0, xpos_q};
    x_right = x_wide + 13'(STEP);

    y_sum  = $signed({2'b00, ypos_q}) + $signed({{6{vel_q[7]}}, vel_q});
    v_inc  = $signed({vel_q[7], vel_q}) + $signed(9'(GRAVITY));
    launch = bus.jump && !jump_prev_q && !airborne_q;

    case (dir)
      DIR_RIGHT: begin
        if (state_q == RIGHT1 || state_q == RIGHT2) begin
          if (anim_cnt_q == ANIM_LAST) begin
            state_n    = (state_q == RIGHT1) ? RIGHT2 : RIGHT1;
            anim_cnt_n = 8'd0;
          end else begin
            anim_cnt_n = anim_cnt_q + 8'd1;
          end
        end else begin
          state_n    = RIGHT1;
          anim_cnt_n = 8'd0;
        end
        xpos_n = (x_right > 13'(X_MAX)) ? 12'(X_MAX) : x_right[11:0];
      end
      DIR_LEFT: begin
        if (state_q == LEFT1 || state_q == LEFT2) begin
          if (anim_cnt_q == ANIM_LAST) begin
            state_n    = (state_q == LEFT1) ? LEFT2 : LEFT1;
            anim_cnt_n = 8'd0;
          end else begin
            anim_cnt_n = anim_cnt_q + 8'd1;
          end
        end else begin
          state_n    = LEFT1;
          anim_cnt_n = 8'd0;
        end
        xpos_n = (x_wide < 13'(X_MIN + STEP)) ? 12'(X_MIN) : 12'(x_wide - 13'(STEP));
      end
      default: begin
        state_n    = IDLE;
        anim_cnt_n = 8'd0;
      end
    endcase

    // Launch tick only arms the jump; the first vertical move happens on the next tick
    if (launch) begin
      vel_n      = 8'(-JUMP_V);
      airborne_n = 1'b1;
    end else if (airborne_q) begin
      if (y_sum >= Y_GROUND_S) begin
        ypos_n     = 12'(Y_GROUND);
        vel_n      = 8'sd0;
        airborne_n = 1'b0;
      end else begin
        ypos_n = (y_sum < 14'sd0) ? 12'd0 : y_sum[11:0];
        vel_n  = (v_inc > V_MAX_S) ? V_MAX_S[7:0] : v_inc[7:0];
      end
    end
  end

  assign bus.xpos_player1 = xpos_q;
  assign bus.ypos_player1 = ypos_q;
  assign bus.airborne     = airborne_q;
  assign state            = state_q;
endmodule

// File: tb/tb_player1_ctl.sv
// Scoreboard bench for player1_ctl: ticks push expected {x,y,state,airborne}; a monitor
// pops and compares one clk after every frame_tick.
module tb_player1_ctl;
  import state_pkg::*;

  logic clk;
  logic rst_n;
  State state;
  player1_ctl_if bus_if ();

  player1_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [27:0] exp_q[$];
  string       name_q[$];
  logic        tick_d;

  int ytab[26] = '{100, 88, 77, 67, 58, 50, 43, 37, 32, 28, 25, 23, 22,
                   22, 23, 25, 28, 32, 37, 43, 50, 58, 67, 77, 88, 100};

  // walk model state
  int   mx;
  int   run;
  int   mdir; // 0 none, 1 right, 2 left
  State mst;

  function automatic logic [27:0] pack(input int x, input int y, input State s, input logic a);
    return {12'(x), 12'(y), 3'(s), a};
  endfunction

  task automatic cmp(input string nm, input logic [27:0] act, input logic [27:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d air=%0d, want x=%0d y=%0d st=%0d air=%0d",
               nm, act[27:16], act[15:4], act[3:1], act[0],
               expv[27:16], expv[15:4], expv[3:1], expv[0]);
    end
  endtask

  // monitor
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= bus_if.frame_tick;
  end

  always @(negedge clk) begin
    if (tick_d) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL no_expect: output update with empty queue");
      end else begin
        cmp(name_q.pop_front(),
            {bus_if.xpos_player1, bus_if.ypos_player1, 3'(state), bus_if.airborne},
            exp_q.pop_front());
      end
    end
  end

  // driver
  task automatic tick(input logic l, input logic r, input logic j, input string nm,
                      input logic [27:0] expv);
    @(negedge clk);
    bus_if.move_left  = l;
    bus_if.move_right = r;
    bus_if.jump       = j;
    bus_if.frame_tick = 1'b1;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(negedge clk);
    bus_if.frame_tick = 1'b0;
  endtask

  // advance the walk model for one tick and issue it
  task automatic step(input logic l, input logic r, input logic j, input int ey,
                      input logic ea, input string nm);
    int d;
    d = (r && !l) ? 1 : (l && !r) ? 2 : 0;
    if (d == 0) begin
      run = 0;
      mst = IDLE;
    end else begin
      run = (d == mdir) ? run + 1 : 1;
      if (d == 1) begin
        mx  = (mx + 2 > 760) ? 760 : mx + 2;
        mst = (((run - 1) / 8) % 2 == 0) ? RIGHT1 : RIGHT2;
      end else begin
        mx  = (mx < 2) ? 0 : mx - 2;
        mst = (((run - 1) / 8) % 2 == 0) ? LEFT1 : LEFT2;
      end
    end
    mdir = d;
    tick(l, r, j, nm, pack(mx, ey, mst, ea));
  endtask

  initial begin
    bus_if.frame_tick = 1'b0;
    bus_if.move_left  = 1'b0;
    bus_if.move_right = 1'b0;
    bus_if.jump       = 1'b0;
    rst_n = 1'b0;
    mx = 100; run = 0; mdir = 0; mst = IDLE;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("reset_state", {bus_if.xpos_player1, bus_if.ypos_player1, 3'(state), bus_if.airborne},
        pack(100, 100, IDLE, 1'b0));

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 100, 1'b0, "idle");

    // 20 ticks right: x 102..140, RIGHT1 1-8, RIGHT2 9-16, RIGHT1 17-20
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 100, 1'b0, "walk_right");
    end
    for (int i = 0; i < 309; i++) step(1'b0, 1'b1, 1'b0, 100, 1'b0, "to_right_wall");
    if (mx != 758) $display("note: model x=%0d before wall", mx);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 100, 1'b0, "right_wall");

    step(1'b1, 1'b1, 1'b0, 100, 1'b0, "both_held");
    step(1'b1, 1'b1, 1'b0, 100, 1'b0, "both_held");

    for (int i = 0; i < 380; i++) step(1'b1, 1'b0, 1'b0, 100, 1'b0, "to_left_wall");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 100, 1'b0, "left_wall");
    step(1'b0, 1'b0, 1'b0, 100, 1'b0, "idle_at_0");

    // jump from ground with a re-press at tick 5
    for (int k = 1; k <= 27; k++) begin
      step(1'b0, 1'b0, (k == 1 || k == 5), (k <= 26) ? ytab[k-1] : 100, (k <= 25), "jump_arc");
    end

    // jump while walking right, then async reset after tick 7
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, (k == 1), ytab[k-1], 1'b1, "walk_jump");
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", {bus_if.xpos_player1, bus_if.ypos_player1, 3'(state), bus_if.airborne},
        pack(100, 100, IDLE, 1'b0));
    mx = 100; run = 0; mdir = 0; mst = IDLE;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("post_reset", {bus_if.xpos_player1, bus_if.ypos_player1, 3'(state), bus_if.airborne},
        pack(100, 100, IDLE, 1'b0));

    step(1'b0, 1'b0, 1'b1, 100, 1'b1, "relaunch");
    step(1'b0, 1'b0, 1'b0, 88, 1'b1, "relaunch");
    step(1'b1, 1'b0, 1'b0, 77, 1'b1, "relaunch_left");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
